// File: rtl/regfile_pkg.sv
// Shared definitions for the register file and its write-port arbiter.
package regfile_pkg;

  localparam int DEFAULT_N_BITS    = 32;
  localparam int DEFAULT_N_REGS    = 32;
  localparam int DEFAULT_ADDR_BITS = 5;

  // Register 0 is hardwired to zero and can never be written.
  localparam int REG_ZERO = 0;

  typedef enum logic {
    INIT,
    RUN
  } state_e;

endpackage

// File: rtl/regfile_onehot_decoder.sv
// Address-to-one-hot write enable decoder. Bit 0 is always low so $zero
// stays zero, and out-of-range addresses decode to no enable at all.
module regfile_onehot_decoder
  import regfile_pkg::*;
#(
  parameter int N_REGS    = DEFAULT_N_REGS,
  parameter int ADDR_BITS = DEFAULT_ADDR_BITS
) (
  input  logic [ADDR_BITS-1:0] addr_i,
  input  logic                 en_i,
  output logic [N_REGS-1:0]    onehot_o
);

  // Compare the address against every writable register index.
  always_comb begin
    onehot_o = '0;
    for (int i = REG_ZERO + 1; i < N_REGS; i++) begin
      if (en_i && (addr_i == ADDR_BITS'(i))) begin
        onehot_o[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Write-port owner for the register file: zero-initialises registers after
// reset, then round-robins between pipeline writeback (requester 0) and the
// long-latency unit (requester 1), presenting one registered write per cycle.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int N_BITS    = DEFAULT_N_BITS,
  parameter int N_REGS    = DEFAULT_N_REGS,
  parameter int ADDR_BITS = DEFAULT_ADDR_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req0_valid_i,
  input  logic [ADDR_BITS-1:0] req0_addr_i,
  input  logic [N_BITS-1:0]    req0_data_i,
  output logic                 req0_ready_o,
  input  logic                 req1_valid_i,
  input  logic [ADDR_BITS-1:0] req1_addr_i,
  input  logic [N_BITS-1:0]    req1_data_i,
  output logic                 req1_ready_o,
  output logic [N_REGS-1:0]    wr_enable_o,
  output logic [ADDR_BITS-1:0] wr_addr_o,
  output logic [N_BITS-1:0]    wr_data_o,
  output logic                 init_busy_o
);

  localparam logic [ADDR_BITS-1:0] FIRST_REG = ADDR_BITS'(REG_ZERO + 1);
  localparam logic [ADDR_BITS-1:0] LAST_REG  = ADDR_BITS'(N_REGS - 1);

  state_e               state_q, state_d;
  logic [ADDR_BITS-1:0] cnt_q, cnt_d;
  logic                 rr_last_q, rr_last_d;
  logic [N_REGS-1:0]    wr_enable_q, wr_enable_d;
  logic [ADDR_BITS-1:0] wr_addr_q, wr_addr_d;
  logic [N_BITS-1:0]    wr_data_q, wr_data_d;

  logic                 in_run;
  logic                 grant0;
  logic                 grant1;
  logic [ADDR_BITS-1:0] dec_addr;
  logic                 dec_en;

  // Round-robin grant: rr_last_q==1 means requester 1 went last, so requester 0 wins a tie.
  always_comb begin
    in_run = (state_q == RUN);
    grant0 = in_run && req0_valid_i && (!req1_valid_i || rr_last_q);
    grant1 = in_run && req1_valid_i && (!req0_valid_i || !rr_last_q);
  end

  // Next-state logic: sweep counter during INIT, granted request during RUN.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rr_last_d = rr_last_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    dec_addr  = wr_addr_q;
    dec_en    = 1'b0;
    case (state_q)
      INIT: begin
        dec_addr  = cnt_q;
        dec_en    = 1'b1;
        wr_addr_d = cnt_q;
        wr_data_d = '0;
        cnt_d     = cnt_q + ADDR_BITS'(1);
        if (cnt_q == LAST_REG) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (grant0) begin
          dec_addr  = req0_addr_i;
          dec_en    = 1'b1;
          wr_addr_d = req0_addr_i;
          wr_data_d = req0_data_i;
          rr_last_d = 1'b0;
        end else if (grant1) begin
          dec_addr  = req1_addr_i;
          dec_en    = 1'b1;
          wr_addr_d = req1_addr_i;
          wr_data_d = req1_data_i;
          rr_last_d = 1'b1;
        end
      end
      default: begin
        state_d = INIT;
      end
    endcase
  end

  regfile_onehot_decoder #(
    .N_REGS    (N_REGS),
    .ADDR_BITS (ADDR_BITS)
  ) u_decoder (
    .addr_i   (dec_addr),
    .en_i     (dec_en),
    .onehot_o (wr_enable_d)
  );

  // State and registered write outputs; low reset restarts the sweep at register 1.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= INIT;
      cnt_q       <= FIRST_REG;
      rr_last_q   <= 1'b1;
      wr_enable_q <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rr_last_q   <= rr_last_d;
      wr_enable_q <= wr_enable_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  assign req0_ready_o = grant0;
  assign req1_ready_o = grant1;
  assign wr_enable_o  = wr_enable_q;
  assign wr_addr_o    = wr_addr_q;
  assign wr_data_o    = wr_data_q;
  assign init_busy_o  = (state_q == INIT);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: stimulus pushes the expected
// write (with the cycle it must appear in) and a monitor compares it.
module tb_regfile_write_arbiter;

  logic        clk;
  logic        reset;
  logic        req0_valid_i;
  logic [4:0]  req0_addr_i;
  logic [31:0] req0_data_i;
  logic        req0_ready_o;
  logic        req1_valid_i;
  logic [4:0]  req1_addr_i;
  logic [31:0] req1_data_i;
  logic        req1_ready_o;
  logic [31:0] wr_enable_o;
  logic [4:0]  wr_addr_o;
  logic [31:0] wr_data_o;
  logic        init_busy_o;

  typedef struct {
    logic [31:0] en;
    logic [31:0] addr;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t exp_q[$];
  int   tests  = 0;
  int   failed = 0;
  int   cyc    = 0;

  regfile_write_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .req0_valid_i (req0_valid_i),
    .req0_addr_i  (req0_addr_i),
    .req0_data_i  (req0_data_i),
    .req0_ready_o (req0_ready_o),
    .req1_valid_i (req1_valid_i),
    .req1_addr_i  (req1_addr_i),
    .req1_data_i  (req1_data_i),
    .req1_ready_o (req1_ready_o),
    .wr_enable_o  (wr_enable_o),
    .wr_addr_o    (wr_addr_o),
    .wr_data_o    (wr_data_o),
    .init_busy_o  (init_busy_o)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle index; a write registered on edge k is seen by the monitor with cyc==k.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failed++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic pushWrite(input logic [31:0] en, input logic [31:0] addr, input logic [31:0] data, input int due);
    exp_t e;
    e.en   = en;
    e.addr = addr;
    e.data = data;
    e.due  = due;
    exp_q.push_back(e);
  endtask

  // Monitor: pop the expected write on its due cycle; any other enable is unexpected.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      checkOutput("wr_enable", wr_enable_o, e.en);
      checkOutput("wr_addr", {27'd0, wr_addr_o}, e.addr);
      checkOutput("wr_data", wr_data_o, e.data);
    end else if (wr_enable_o != 32'd0) begin
      checkOutput("unexpected_write", wr_enable_o, 32'd0);
    end
  end

  // One RUN cycle: drive both requesters at the falling edge, check readies, queue the write.
  task automatic applyStimulus(
    input logic v0, input logic [4:0] a0, input logic [31:0] d0,
    input logic v1, input logic [4:0] a1, input logic [31:0] d1,
    input logic er0, input logic er1,
    input bit exp_wr, input logic [31:0] exp_en, input logic [31:0] exp_addr, input logic [31:0] exp_data);
    @(negedge clk);
    req0_valid_i = v0;
    req0_addr_i  = a0;
    req0_data_i  = d0;
    req1_valid_i = v1;
    req1_addr_i  = a1;
    req1_data_i  = d1;
    #1;
    checkOutput("req0_ready", {31'd0, req0_ready_o}, {31'd0, er0});
    checkOutput("req1_ready", {31'd0, req1_ready_o}, {31'd0, er1});
    if (exp_wr) pushWrite(exp_en, exp_addr, exp_data, cyc + 1);
  endtask

  // Release reset and follow n_edges sweep writes with both requesters pushing (they must be ignored).
  task automatic runSweep(input int n_edges);
    reset        = 1'b1;
    req0_valid_i = 1'b1;
    req0_addr_i  = 5'd4;
    req0_data_i  = 32'h4444_4444;
    req1_valid_i = 1'b1;
    req1_addr_i  = 5'd6;
    req1_data_i  = 32'h6666_6666;
    #1;
    checkOutput("reset_wr_enable", wr_enable_o, 32'd0);
    checkOutput("reset_wr_addr", {27'd0, wr_addr_o}, 32'd0);
    checkOutput("reset_wr_data", wr_data_o, 32'd0);
    checkOutput("reset_init_busy", {31'd0, init_busy_o}, 32'd1);
    for (int i = 1; i <= n_edges; i++) begin
      pushWrite(32'd1 << i, i, 32'd0, cyc + i);
    end
    for (int i = 1; i <= n_edges; i++) begin
      @(negedge clk);
      #1;
      if (i < 31) begin
        checkOutput("init_ready0", {31'd0, req0_ready_o}, 32'd0);
        checkOutput("init_ready1", {31'd0, req1_ready_o}, 32'd0);
        checkOutput("init_busy", {31'd0, init_busy_o}, 32'd1);
      end else begin
        req0_valid_i = 1'b0;
        req1_valid_i = 1'b0;
        #1;
        checkOutput("init_busy_done", {31'd0, init_busy_o}, 32'd0);
      end
    end
  endtask

  // Safety net in case the run never reaches the summary.
  initial begin
    #50000;
    $display("[TB] FAIL watchdog: timeout expected finish before 50000");
    $fatal(1, "[TB] timeout");
  end

  // Directed sequence.
  initial begin
    reset        = 1'b0;
    req0_valid_i = 1'b0;
    req0_addr_i  = '0;
    req0_data_i  = '0;
    req1_valid_i = 1'b0;
    req1_addr_i  = '0;
    req1_data_i  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);

    // Full sweep after power-up.
    runSweep(31);

    // Single writeback from requester 0, then idle: address/data must hold.
    applyStimulus(1, 5'd5, 32'hDEAD_BEEF, 0, 5'd0, 32'd0, 1, 0, 1, 32'h0000_0020, 5, 32'hDEAD_BEEF);
    applyStimulus(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    checkOutput("hold_wr_enable", wr_enable_o, 32'd0);
    checkOutput("hold_wr_addr", {27'd0, wr_addr_o}, 32'd5);
    checkOutput("hold_wr_data", wr_data_o, 32'hDEAD_BEEF);

    // Write to $zero from requester 1: accepted, no enable; leaves requester 1 as last.
    applyStimulus(0, 5'd0, 32'd0, 1, 5'd0, 32'h1234, 0, 1, 0, 0, 0, 0);

    // Sustained contention: strict alternation starting with requester 0.
    applyStimulus(1, 5'd3, 32'h33, 1, 5'd7, 32'h77, 1, 0, 1, 32'h0000_0008, 3, 32'h33);
    applyStimulus(1, 5'd3, 32'h33, 1, 5'd7, 32'h77, 0, 1, 1, 32'h0000_0080, 7, 32'h77);
    applyStimulus(1, 5'd3, 32'h33, 1, 5'd7, 32'h77, 1, 0, 1, 32'h0000_0008, 3, 32'h33);
    applyStimulus(1, 5'd3, 32'h33, 1, 5'd7, 32'h77, 0, 1, 1, 32'h0000_0080, 7, 32'h77);

    // Same destination: requester 0 first, loser writes the next cycle.
    applyStimulus(1, 5'd9, 32'hA, 1, 5'd9, 32'hB, 1, 0, 1, 32'h0000_0200, 9, 32'hA);
    applyStimulus(0, 5'd0, 32'd0, 1, 5'd9, 32'hB, 0, 1, 1, 32'h0000_0200, 9, 32'hB);

    // Top register, then an uncontended requester 0 grant flips priority to requester 1.
    applyStimulus(0, 5'd0, 32'd0, 1, 5'd31, 32'hCAFE_F00D, 0, 1, 1, 32'h8000_0000, 31, 32'hCAFE_F00D);
    applyStimulus(1, 5'd1, 32'h11, 0, 5'd0, 32'd0, 1, 0, 1, 32'h0000_0002, 1, 32'h11);
    applyStimulus(1, 5'd2, 32'h1, 1, 5'd4, 32'h2, 0, 1, 1, 32'h0000_0010, 4, 32'h2);
    applyStimulus(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 0, 0, 0, 0, 0);

    // Reset mid-sweep at count 12: the sweep restarts from register 1.
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    runSweep(11);
    reset        = 1'b0;
    req0_valid_i = 1'b0;
    req1_valid_i = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("midinit_wr_enable", wr_enable_o, 32'd0);
    checkOutput("midinit_wr_addr", {27'd0, wr_addr_o}, 32'd0);
    checkOutput("midinit_init_busy", {31'd0, init_busy_o}, 32'd1);
    runSweep(31);

    // Reset during RUN traffic: registered write is cleared, concurrent acceptance discarded.
    applyStimulus(1, 5'd6, 32'h66, 0, 5'd0, 32'd0, 1, 0, 1, 32'h0000_0040, 6, 32'h66);
    @(negedge clk);
    reset        = 1'b0;
    req0_addr_i  = 5'd8;
    req0_data_i  = 32'h88;
    @(negedge clk);
    #1;
    checkOutput("midrun_wr_enable", wr_enable_o, 32'd0);
    checkOutput("midrun_wr_addr", {27'd0, wr_addr_o}, 32'd0);
    checkOutput("midrun_wr_data", wr_data_o, 32'd0);
    checkOutput("midrun_init_busy", {31'd0, init_busy_o}, 32'd1);
    checkOutput("midrun_ready0", {31'd0, req0_ready_o}, 32'd0);
    req0_valid_i = 1'b0;
    runSweep(31);

    // Priority pointer was reset too: requester 0 wins the first contention.
    applyStimulus(1, 5'd2, 32'h22, 1, 5'd3, 32'h33, 1, 0, 1, 32'h0000_0004, 2, 32'h22);
    applyStimulus(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    #1;
    checkOutput("scoreboard_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
